// File: rtl/mem_refill_arb.sv
// Two-port cache line refill arbiter onto one fixed-latency memory read port.
// Bursts run to completion (or abandonment); ties alternate via prio.
module mem_refill_arb #(
  parameter int BLOCK_WIDTH = 3,
  parameter int RD_LATENCY  = 2
) (
  input  logic        i_ck,
  input  logic        i_rb,
  input  logic        i_p0_req,
  input  logic [29:0] i_p0_addr,
  output logic        o_p0_ack,
  output logic [31:0] o_p0_data,
  input  logic        i_p1_req,
  input  logic [29:0] i_p1_addr,
  output logic        o_p1_ack,
  output logic [31:0] o_p1_data,
  output logic        o_ram_rd,
  output logic [29:0] o_ram_addr,
  input  logic [31:0] i_ram_data,
  output logic        o_busy,
  output logic        o_grant
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

  logic [1:0]             state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   prio_q, prio_d;
  logic [BLOCK_WIDTH-1:0] beat_q, beat_d;
  logic [3:0]             lat_q, lat_d;
  logic [31:0]            rdata_q, rdata_d;

  logic req_g;
  logic beat_last;

  assign req_g     = grant_q ? i_p1_req : i_p0_req;
  assign beat_last = &beat_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_p0_req | i_p1_req) begin
          grant_d = (i_p0_req & i_p1_req) ? prio_q : i_p1_req;
          beat_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q != 4'd0) begin
          lat_d = lat_q - 4'd1;
        end else begin
          rdata_d = i_ram_data;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        // an abandoned line ends here too, after its read has drained
        if (beat_last || !req_g) begin
          prio_d  = ~grant_q;
          state_d = S_IDLE;
        end else begin
          beat_d  = beat_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_ck or negedge i_rb) begin
    if (!i_rb) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      beat_q  <= '0;
      lat_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_ram_rd   = (state_q == S_ISSUE);
  assign o_ram_addr = !o_ram_rd ? 30'd0 :
                      (grant_q ? i_p1_addr : i_p0_addr);
  assign o_p0_ack   = (state_q == S_ACK) & ~grant_q & i_p0_req;
  assign o_p1_ack   = (state_q == S_ACK) & grant_q & i_p1_req;
  assign o_p0_data  = rdata_q;
  assign o_p1_data  = rdata_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_grant    = grant_q;

endmodule

// File: tb/tb_mem_refill_arb.sv
// Bench for mem_refill_arb: three instances (latency 2, 1, 15) share one
// directed scenario; a cycle-offset model checks every output each cycle.
module tb_mem_refill_arb;

  logic        clk;
  logic        rb    [3];
  logic        req   [3][2];
  logic [29:0] addr  [3][2];
  logic        ack   [3][2];
  logic [31:0] dat   [3][2];
  logic        rd    [3];
  logic [29:0] raddr [3];
  logic [31:0] rdat  [3];
  logic        busy  [3];
  logic        grant [3];

  int cyc;
  int checks;
  int errors;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    logic [31:0] pipe [16];

    mem_refill_arb #(
      .BLOCK_WIDTH(3),
      .RD_LATENCY (L)
    ) u_dut (
      .i_ck      (clk),
      .i_rb      (rb[g]),
      .i_p0_req  (req[g][0]),
      .i_p0_addr (addr[g][0]),
      .o_p0_ack  (ack[g][0]),
      .o_p0_data (dat[g][0]),
      .i_p1_req  (req[g][1]),
      .i_p1_addr (addr[g][1]),
      .o_p1_ack  (ack[g][1]),
      .o_p1_data (dat[g][1]),
      .o_ram_rd  (rd[g]),
      .o_ram_addr(raddr[g]),
      .i_ram_data(rdat[g]),
      .o_busy    (busy[g]),
      .o_grant   (grant[g])
    );

    // memory[a] = a, delivered exactly L cycles after the strobe
    always @(posedge clk) begin
      pipe[0] <= rd[g] ? {2'b00, raddr[g]} : (32'hbad0_0000 ^ 32'(cyc));
      for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
    end
    assign rdat[g] = pipe[L-1];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit          m_busy  [3];
  bit          m_own   [3];
  bit          m_prio  [3];
  bit          m_grant [3];
  int          m_start [3];
  logic [31:0] m_data  [3];
  logic [31:0] m_iss   [3];

  bit          ackf      [3][2];
  int          left      [3][2];
  int          req_cyc   [3][2];
  int          n_ack     [3][2];
  int          ack_cyc   [3][2][64];
  logic [31:0] ack_dat   [3][2][64];
  bit          pend      [2];
  logic [29:0] pend_base [2];
  bit          pend_rel;
  int          trig_kind [3];
  int          trig_beat [3];

  function automatic int per(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 3 : 17);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic zero_chk(input int i);
    chk($sformatf("rst ack0[%0d]", i), 32'(ack[i][0]), 32'd0);
    chk($sformatf("rst ack1[%0d]", i), 32'(ack[i][1]), 32'd0);
    chk($sformatf("rst dat0[%0d]", i), dat[i][0], 32'd0);
    chk($sformatf("rst dat1[%0d]", i), dat[i][1], 32'd0);
    chk($sformatf("rst rd[%0d]", i), 32'(rd[i]), 32'd0);
    chk($sformatf("rst raddr[%0d]", i), 32'(raddr[i]), 32'd0);
    chk($sformatf("rst busy[%0d]", i), 32'(busy[i]), 32'd0);
    chk($sformatf("rst grant[%0d]", i), 32'(grant[i]), 32'd0);
  endtask

  task automatic start_cache(input int i, input int p, input logic [29:0] b);
    req[i][p]     = 1'b1;
    addr[i][p]    = b;
    left[i][p]    = 8;
    req_cyc[i][p] = cyc;
  endtask

  // expected outputs derived from the cycle offset into the current line
  task automatic do_model(input int i);
    int P, off, b, ph;
    bit was, rde;
    bit ae [2];
    P = per(i);
    if (!rb[i]) begin
      zero_chk(i);
      m_busy[i]  = 1'b0;
      m_grant[i] = 1'b0;
      m_prio[i]  = 1'b0;
      m_data[i]  = 32'd0;
      ackf[i][0] = 1'b0;
      ackf[i][1] = 1'b0;
      return;
    end
    was   = m_busy[i];
    rde   = 1'b0;
    ae[0] = 1'b0;
    ae[1] = 1'b0;
    b     = 0;
    ph    = 0;
    if (was) begin
      off = cyc - m_start[i];
      b   = off / P;
      ph  = off % P;
      if (ph == 0) begin
        rde      = 1'b1;
        m_iss[i] = {2'b00, addr[i][m_own[i]]};
        chk($sformatf("raddr[%0d]", i), {2'b00, raddr[i]}, m_iss[i]);
      end
      if (ph == P - 1) begin
        m_data[i] = m_iss[i];
        if (req[i][m_own[i]]) ae[m_own[i]] = 1'b1;
      end
    end
    chk($sformatf("rd[%0d]", i), 32'(rd[i]), 32'(rde));
    chk($sformatf("ack0[%0d]", i), 32'(ack[i][0]), 32'(ae[0]));
    chk($sformatf("ack1[%0d]", i), 32'(ack[i][1]), 32'(ae[1]));
    chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(was));
    chk($sformatf("grant[%0d]", i), 32'(grant[i]), 32'(m_grant[i]));
    chk($sformatf("dat0[%0d]", i), dat[i][0], m_data[i]);
    chk($sformatf("dat1[%0d]", i), dat[i][1], m_data[i]);
    for (int p = 0; p < 2; p++) begin
      ackf[i][p] = ack[i][p];
      if (ack[i][p]) begin
        if (n_ack[i][p] < 64) begin
          ack_cyc[i][p][n_ack[i][p]] = cyc;
          ack_dat[i][p][n_ack[i][p]] = dat[i][p];
        end
        n_ack[i][p]++;
      end
    end
    if (was) begin
      if (ph == P - 1 && (b == 7 || !req[i][m_own[i]])) begin
        m_busy[i] = 1'b0;
        m_prio[i] = !m_own[i];
      end
    end else if (req[i][0] || req[i][1]) begin
      m_own[i]   = (req[i][0] && req[i][1]) ? m_prio[i] : req[i][1];
      m_grant[i] = m_own[i];
      m_busy[i]  = 1'b1;
      m_start[i] = cyc + 1;
    end
  endtask

  task automatic tick();
    bit rst_now [3];
    int off, P;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      rst_now[i] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (ackf[i][p] && req[i][p]) begin
          addr[i][p] = addr[i][p] + 30'd1;
          left[i][p]--;
          if (left[i][p] == 0) req[i][p] = 1'b0;
        end
      end
      if (pend_rel) rb[i] = 1'b1;
      for (int p = 0; p < 2; p++)
        if (pend[p]) start_cache(i, p, pend_base[p]);
      if (trig_kind[i] != 0 && m_busy[i] && rb[i]) begin
        P   = per(i);
        off = cyc - m_start[i];
        if (off / P == trig_beat[i] && off % P == 1) begin
          if (trig_kind[i] == 1) begin
            start_cache(i, 1, 30'h600);
          end else if (trig_kind[i] == 2) begin
            req[i][0]  = 1'b0;
            left[i][0] = 0;
            start_cache(i, 1, 30'h680);
          end else begin
            rb[i]      = 1'b0;
            req[i][0]  = 1'b0;
            req[i][1]  = 1'b0;
            left[i][0] = 0;
            left[i][1] = 0;
            rst_now[i] = 1'b1;
          end
          trig_kind[i] = 0;
        end
      end
    end
    pend[0]  = 1'b0;
    pend[1]  = 1'b0;
    pend_rel = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      if (rst_now[i]) zero_chk(i);
    @(negedge clk);
    for (int i = 0; i < 3; i++) do_model(i);
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < 3; i++)
      if (m_busy[i] || req[i][0] || req[i][1] || trig_kind[i] != 0)
        return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!all_idle() && n < bound);
    checks++;
    if (!all_idle()) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, need idle", n);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      n_ack[i][0] = 0;
      n_ack[i][1] = 0;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) rb[i] = 1'b0;
    repeat (2) tick();
    pend_rel = 1'b1;
    tick();
  endtask

  task automatic start(input int p, input logic [29:0] b);
    pend[p]      = 1'b1;
    pend_base[p] = b;
  endtask

  task automatic set_trig(input int kind, input int beat);
    for (int i = 0; i < 3; i++) begin
      trig_kind[i] = kind;
      trig_beat[i] = beat;
    end
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    pend_rel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rb[i]        = 1'b0;
      trig_kind[i] = 0;
      for (int p = 0; p < 2; p++) begin
        req[i][p]  = 1'b0;
        addr[i][p] = 30'd0;
        left[i][p] = 0;
        ackf[i][p] = 1'b0;
      end
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    repeat (3) tick();
    pend_rel = 1'b1;
    tick();

    // single port-0 line
    clr();
    start(0, 30'h100);
    wait_idle(400);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1 n_ack[%0d]", i), 32'(n_ack[i][0]), 32'd8);
      chk($sformatf("t1 last data[%0d]", i), ack_dat[i][0][7], 32'h107);
    end
    chk("t1 first ack L2", 32'(ack_cyc[0][0][0] - req_cyc[0][0]), 32'd4);
    chk("t1 last ack L2", 32'(ack_cyc[0][0][7] - req_cyc[0][0]), 32'd32);
    chk("t1 period L1", 32'(ack_cyc[1][0][1] - ack_cyc[1][0][0]), 32'd3);
    chk("t1 last ack L1", 32'(ack_cyc[1][0][7] - req_cyc[1][0]), 32'd24);
    chk("t1 period L15", 32'(ack_cyc[2][0][1] - ack_cyc[2][0][0]), 32'd17);
    chk("t1 last ack L15", 32'(ack_cyc[2][0][7] - req_cyc[2][0]), 32'd136);

    // tie after reset: port 0 first
    do_reset();
    clr();
    start(0, 30'h200);
    start(1, 30'h300);
    wait_idle(800);
    chk("t2 p0 first", 32'(ack_cyc[0][0][0] - req_cyc[0][0]), 32'd4);
    chk("t2 p1 first", 32'(ack_cyc[0][1][0] - req_cyc[0][1]), 32'd37);
    chk("t2 p1 n_ack", 32'(n_ack[0][1]), 32'd8);
    chk("t2 p1 last data", ack_dat[0][1][7], 32'h307);

    // after a port-0 line, the next tie goes to port 1
    clr();
    start(0, 30'h400);
    wait_idle(400);
    clr();
    start(0, 30'h480);
    start(1, 30'h500);
    wait_idle(800);
    chk("t4 p1 first", 32'(ack_cyc[0][1][0] - req_cyc[0][1]), 32'd4);
    chk("t4 p0 first", 32'(ack_cyc[0][0][0] - req_cyc[0][0]), 32'd37);
    chk("t4 p1 first L15", 32'(ack_cyc[2][1][0] - req_cyc[2][1]), 32'd17);

    // port 1 arrives at beat 3 of a port-0 line
    clr();
    start(0, 30'h520);
    set_trig(1, 3);
    wait_idle(800);
    chk("t5 gap L2", 32'(ack_cyc[0][1][0] - ack_cyc[0][0][7]), 32'd5);
    chk("t5 gap L15", 32'(ack_cyc[2][1][0] - ack_cyc[2][0][7]), 32'd18);
    chk("t5 p1 n_ack", 32'(n_ack[0][1]), 32'd8);

    // port 0 abandons in beat 2 WAIT, port 1 asks at the same time
    clr();
    start(0, 30'h540);
    set_trig(2, 2);
    wait_idle(800);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t6 p0 n_ack[%0d]", i), 32'(n_ack[i][0]), 32'd2);
    chk("t6 gap L2", 32'(ack_cyc[0][1][0] - ack_cyc[0][0][1]), 32'd9);
    chk("t6 gap L1", 32'(ack_cyc[1][1][0] - ack_cyc[1][0][1]), 32'd7);
    chk("t6 p1 first data", ack_dat[0][1][0], 32'h680);

    // reset during beat 5 WAIT, then a fresh line
    clr();
    start(0, 30'h560);
    set_trig(3, 5);
    wait_idle(800);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t7 p0 n_ack[%0d]", i), 32'(n_ack[i][0]), 32'd5);
    pend_rel = 1'b1;
    repeat (20) tick();
    clr();
    start(0, 30'h700);
    wait_idle(400);
    chk("t7 restart first", 32'(ack_cyc[0][0][0] - req_cyc[0][0]), 32'd4);
    chk("t7 restart data", ack_dat[0][0][0], 32'h700);
    chk("t7 restart n_ack", 32'(n_ack[0][0]), 32'd8);
    chk("t7 restart L15 n_ack", 32'(n_ack[2][0]), 32'd8);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
